// File: rtl/subcarrier_pkg.sv
// subcarrier_pkg: shared types and constants for the ISO/IEC 14443-2A PICC
// subcarrier generator and its helpers.
//   div_sel_t       : divisor select encoding for the fc/16 family
//   sc_state_t      : generator FSM state encoding
//   CARRIER_FREQ_HZ : nominal carrier frequency (13.56 MHz)
//   half_period()   : subcarrier half-period in carrier cycles for a div_sel_t
package subcarrier_pkg;

  localparam int CARRIER_FREQ_HZ = 13560000;

  // Largest divisor log2 that the div_sel_t encoding describes (fc/16).
  localparam int FIXED_DIV_LOG2 = 4;

  typedef enum logic [1:0] {
    DIV_16 = 2'd0,
    DIV_8  = 2'd1,
    DIV_4  = 2'd2,
    DIV_2  = 2'd3
  } div_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sc_state_t;

  function automatic int half_period(input div_sel_t sel);
    case (sel)
      DIV_16:  return 8;
      DIV_8:   return 4;
      DIV_4:   return 2;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/etu_counter.sv
// etu_counter: free-running bit-period (ETU) counter with a one-cycle strobe.
// Shared between the transmit subcarrier generator and the receive bit sampler.
//   clk  : carrier clock
//   rst  : asynchronous active-high reset
//   step : high when the following cycle is a counted cycle; low clears the count
//   tick : high during every ETU_CYCLES-th counted cycle
module etu_counter #(
  parameter int ETU_CYCLES = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic tick
);

  localparam int CW = (ETU_CYCLES > 1) ? $clog2(ETU_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ETU_CYCLES - 1);

  // cnt_p0 holds how many counted cycles of the current bit period have
  // already elapsed, so the strobe is registered for the cycle that ends it.
  logic [CW-1:0] cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      tick   <= 1'b0;
    end else if (!step) begin
      cnt_p0 <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= (cnt_p0 == LAST);
      cnt_p0 <= (cnt_p0 == LAST) ? '0 : cnt_p0 + CW'(1);
    end
  end

endmodule

// File: rtl/subcarrier_gen.sv
// subcarrier_gen: load-modulation subcarrier generator for the ISO/IEC 14443-2A
// PICC transmit path. Produces fc/2^(MAX_DIV_LOG2-div_sel) with 50% duty,
// optional BPSK phase inversion and a bit-period strobe.
//   clk        : 13.56 MHz carrier clock
//   rst        : asynchronous active-high reset
//   en         : subcarrier enable
//   div_sel    : divisor select, 0 = fc/2^MAX_DIV_LOG2; out-of-range values use H=1
//   invert     : BPSK phase request, taken at full-period boundaries
//   subcarrier : subcarrier to the load modulator
//   bit_tick   : one-cycle strobe at each bit-period boundary
//   active     : high during every running cycle
// Build option: define SUBCARRIER_GEN_BPSK_EN to honour invert; otherwise the
// phase is fixed at 0 and no phase register exists.
module subcarrier_gen
  import subcarrier_pkg::*;
#(
  parameter int MAX_DIV_LOG2 = 4,
  parameter int ETU_CYCLES   = 128,
  parameter int DIV_SEL_W    = (MAX_DIV_LOG2 > 1) ? $clog2(MAX_DIV_LOG2) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_SEL_W-1:0] div_sel,
  input  logic                 invert,
  output logic                 subcarrier,
  output logic                 bit_tick,
  output logic                 active
);

  localparam int HW = (MAX_DIV_LOG2 > 1) ? MAX_DIV_LOG2 - 1 : 1;
  localparam logic [DIV_SEL_W-1:0] SEL_MAX = DIV_SEL_W'(MAX_DIV_LOG2 - 1);

`ifdef SUBCARRIER_GEN_BPSK_EN
  localparam bit BPSK_EN = 1'b1;
`else
  localparam bit BPSK_EN = 1'b0;
`endif

  sc_state_t            state_p0, state_d;
  logic [DIV_SEL_W-1:0] sel_p0, sel_d, sel_legal;
  logic [HW-1:0]        hcnt_p0, hcnt_d;
  logic                 raw_p0, raw_d;
  logic                 phase_p0, phase_d;
  logic                 sc_p0, sc_d;
  logic                 req_phase;

  // Terminal value of the half-period counter, i.e. H-1.
  function automatic logic [HW-1:0] half_max(input logic [DIV_SEL_W-1:0] sel);
    logic [31:0] sel32;
    int          h;
    sel32 = 32'(sel);
    if (MAX_DIV_LOG2 == FIXED_DIV_LOG2)
      h = half_period(div_sel_t'(sel32[1:0]));
    else
      h = 1 << (MAX_DIV_LOG2 - 1 - int'(sel32));
    return HW'(h - 1);
  endfunction

  assign req_phase = BPSK_EN & invert;
  assign sel_legal = (32'(div_sel) >= 32'(MAX_DIV_LOG2)) ? SEL_MAX : div_sel;

  // raw is the non-inverted waveform; its 0->1 transition is the full-period
  // boundary where a new phase may be taken, so the inverted output never
  // produces a pulse shorter than H.
  always_comb begin
    state_d = state_p0;
    sel_d   = sel_p0;
    hcnt_d  = hcnt_p0;
    raw_d   = raw_p0;
    phase_d = phase_p0;
    case (state_p0)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          sel_d   = sel_legal;
          hcnt_d  = '0;
          raw_d   = 1'b1;
          phase_d = req_phase;
        end
      end
      default: begin
        // Disable takes priority over any period boundary in the same cycle.
        if (!en) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          hcnt_d  = '0;
          raw_d   = 1'b0;
          phase_d = 1'b0;
        end else if (hcnt_p0 == half_max(sel_p0)) begin
          hcnt_d = '0;
          raw_d  = ~raw_p0;
          if (!raw_p0)
            phase_d = req_phase;
        end else begin
          hcnt_d = hcnt_p0 + HW'(1);
        end
      end
    endcase
    sc_d = (state_d == ST_RUN) & (raw_d ^ phase_d);
  end

  // ---- stage p0: generator state and registered output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      sel_p0   <= '0;
      hcnt_p0  <= '0;
      raw_p0   <= 1'b0;
      sc_p0    <= 1'b0;
    end else begin
      state_p0 <= state_d;
      sel_p0   <= sel_d;
      hcnt_p0  <= hcnt_d;
      raw_p0   <= raw_d;
      sc_p0    <= sc_d;
    end
  end

`ifdef SUBCARRIER_GEN_BPSK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase_p0 <= 1'b0;
    else
      phase_p0 <= phase_d;
  end
`else
  assign phase_p0 = 1'b0;
  logic unused_phase;
  assign unused_phase = phase_d;
`endif

  etu_counter #(
    .ETU_CYCLES(ETU_CYCLES)
  ) u_etu (
    .clk (clk),
    .rst (rst),
    .step(en),
    .tick(bit_tick)
  );

  assign subcarrier = sc_p0;
  assign active     = (state_p0 == ST_RUN);

endmodule
